bus_arbiter_nslave: RTL and testbench
=====================================

Name: bus_arbiter_nslave

Overview:
- Parametrised, registered successor of the combinational address bus.
- Decodes one master data port onto NUM_SLAVES memory-mapped regions, each defined by a base/mask pair.
- Holds the selected slave strobe until that slave acknowledges, then returns data with a one-cycle ready pulse.
- Supports variable-latency peripherals (flash, USB, CLINT), a default slave, decode-error reporting and a watchdog timeout for hung slaves.

Parameters:
NUM_SLAVES, 8, number of slave regions (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
REGION_BASE, {NUM_SLAVES*ADDR_W} zeros, flat base vector; slave i occupies bits [i*ADDR_W +: ADDR_W]
REGION_MASK, {NUM_SLAVES*ADDR_W} ones, flat mask vector; slave i matches when (addr & MASK_i) == BASE_i
DEFAULT_SLAVE, NUM_SLAVES-1, slave used when no region matches; a value >= NUM_SLAVES means no default, so an unmatched access is a decode error
TIMEOUT_CYCLES, 255, maximum cycles to wait for s_ack; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_addr  in  ADDR_W  master address
m_wdata  in  DATA_W  master write data
m_ren  in  1  master read request
m_wen  in  1  master write request
m_ready  out  1  one-cycle pulse marking transfer completion
m_rdata  out  DATA_W  read data; valid while m_ready=1
m_err  out  1  error flag; valid while m_ready=1
s_addr  out  ADDR_W  latched address, broadcast to all slaves
s_wdata  out  DATA_W  latched write data, broadcast to all slaves
s_ren  out  NUM_SLAVES  per-slave read strobe
s_wen  out  NUM_SLAVES  per-slave write strobe
s_rdata  in  NUM_SLAVES*DATA_W  flat slave read data
s_ack  in  NUM_SLAVES  per-slave completion
timeout_flag  out  1  sticky; set on a timeout, cleared only by reset

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset is sampled on clk; if asserted mid-transfer, the block returns to IDLE and drops all strobes on the next edge. No m_ready is produced for the aborted transfer.
- States: IDLE, WAIT, RESP.
- Decode (combinational on m_addr, used only in IDLE):
  - Priority goes to the lowest matching index.
  - If nothing matches, DEFAULT_SLAVE is selected when it is valid; otherwise a decode error is raised.
- IDLE:
  - Stays in IDLE while m_ren|m_wen = 0.
  - m_ren=1 and m_wen=1 together -> RESP with m_err=1, no slave strobed.
  - Decode error -> RESP with m_err=1, m_rdata=0, no strobe.
  - Otherwise latch m_addr, m_wdata, the operation and the slave index; next cycle drive s_ren[idx] or s_wen[idx] = 1; go to WAIT.
- WAIT:
  - Exactly one strobe bit is high. s_addr and s_wdata are stable.
  - s_ack[idx]=1 -> capture s_rdata slice idx into m_rdata (writes capture 0); drop the strobe on the same edge; go to RESP.
  - Acks from non-selected slaves are ignored.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no ack: drop the strobe, set m_err=1, m_rdata=0, set timeout_flag, go to RESP.
  - If the ack and the timeout occur in the same cycle, the ack wins (no error).
- RESP:
  - m_ready=1 for exactly one cycle, then IDLE. The counter clears.
  - m_rdata and m_err are held until the next RESP; they are meaningful only while m_ready=1.
  - Master requests are not sampled in RESP. A request still held is re-accepted in IDLE, so the master must drop ren/wen in the cycle after m_ready.
- Latency: accept at edge N, strobe high during N+1. An ack in N+1 gives m_ready in N+2. The minimum is therefore 2 cycles from acceptance to m_ready; an error response is m_ready one cycle after acceptance.
- Only one transfer is outstanding at a time; there is no pipelining.
- Address compare uses the full ADDR_W; there is no wrap-around between regions.

Test Plan:
- NUM_SLAVES=4, BASE={0x0,0x1000_0000,0x2000_0000,0x3000_0000}, MASK=0xF000_0000. Read 0x2000_0010 with slave 2 acking immediately, s_rdata2=0xDEADBEEF -> s_ren=4'b0100 for 1 cycle, m_ready 2 cycles after acceptance, m_rdata=0xDEADBEEF, m_err=0.
- Write 0x1000_0004 data 0x55, slave 1 acks after 5 cycles -> s_wen=4'b0010 held 6 cycles, s_wdata=0x55 stable throughout, one m_ready pulse, m_err=0.
- DEFAULT_SLAVE=4 (none), read 0x4000_0000 -> no strobe, m_ready next cycle, m_err=1, m_rdata=0.
- TIMEOUT_CYCLES=8, slave 3 never acks -> strobe drops after 8 WAIT cycles, m_err=1, timeout_flag=1 and stays 1 through later good transfers until reset.
- Ack arrives in the same cycle the counter hits the limit -> m_err=0, data returned, timeout_flag unchanged.
- Reset asserted during WAIT -> next cycle all s_ren/s_wen=0, m_ready never pulses; a new read after reset completes normally. Separately, m_ren=m_wen=1 -> m_err=1 with no strobe.

Source files
------------

// File: rtl/bus_arbiter_nslave.sv
// Registered single-master address decoder: routes one master port onto NUM_SLAVES
// base/mask regions, holds the strobe until ack, reports decode errors and hung slaves.

module bus_arbiter_nslave_region #(
    parameter int                ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] MASK   = '1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    assign hit = ((addr & MASK) == BASE);
endmodule

module bus_arbiter_nslave #(
    parameter int                           NUM_SLAVES     = 8,
    parameter int                           ADDR_W         = 32,
    parameter int                           DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_BASE    = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] REGION_MASK    = '1,
    parameter int                           DEFAULT_SLAVE  = NUM_SLAVES - 1,
    parameter int                           TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_ren,
    input  logic                         m_wen,
    output logic                         m_ready,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [NUM_SLAVES-1:0]        s_ren,
    output logic [NUM_SLAVES-1:0]        s_wen,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    output logic                         timeout_flag
);
    localparam int IDX_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit HAS_DEFAULT = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NUM_SLAVES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wr;
        logic [IDX_W-1:0]  idx;
    } req_t;

    state_t                             state;
    req_t                               req;
    logic [CNT_W-1:0]                   cnt;
    logic [NUM_SLAVES-1:0]              hit;
    logic [IDX_W-1:0]                   dec_idx;
    logic                               dec_err;
    logic [NUM_SLAVES-1:0]              dec_oh;
    logic [NUM_SLAVES-1:0][DATA_W-1:0]  s_rdata_a;
    logic                               to_hit;

    assign s_rdata_a = s_rdata;
    assign s_addr    = req.addr;
    assign s_wdata   = req.wdata;

    genvar i;
    generate
        for (i = 0; i < NUM_SLAVES; i++) begin : g_region
            bus_arbiter_nslave_region #(
                .ADDR_W (ADDR_W),
                .BASE   (REGION_BASE[i*ADDR_W +: ADDR_W]),
                .MASK   (REGION_MASK[i*ADDR_W +: ADDR_W])
            ) u_region (
                .addr (m_addr),
                .hit  (hit[i])
            );
        end
    endgenerate

    // Scan high-to-low so the lowest matching index is the one left standing.
    always_comb begin
        dec_idx = '0;
        dec_err = 1'b1;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                dec_idx = IDX_W'(k);
                dec_err = 1'b0;
            end
        end
        if (dec_err && HAS_DEFAULT) begin
            dec_idx = IDX_W'(DEFAULT_SLAVE);
            dec_err = 1'b0;
        end
    end

    always_comb begin
        dec_oh          = '0;
        dec_oh[dec_idx] = 1'b1;
    end

    // cnt holds the number of completed WAIT cycles, so the limit is TIMEOUT_CYCLES-1.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_to
            assign to_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_to
            assign to_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req          <= '0;
            cnt          <= '0;
            s_ren        <= '0;
            s_wen        <= '0;
            m_ready      <= 1'b0;
            m_rdata      <= '0;
            m_err        <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_ren || m_wen) begin
                        if ((m_ren && m_wen) || dec_err) begin
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end else begin
                            req.addr  <= m_addr;
                            req.wdata <= m_wdata;
                            req.wr    <= m_wen;
                            req.idx   <= dec_idx;
                            s_ren     <= m_ren ? dec_oh : '0;
                            s_wen     <= m_wen ? dec_oh : '0;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // An ack landing on the limit cycle still completes cleanly.
                    if (s_ack[req.idx]) begin
                        m_rdata <= req.wr ? '0 : s_rdata_a[req.idx];
                        m_err   <= 1'b0;
                        m_ready <= 1'b1;
                        s_ren   <= '0;
                        s_wen   <= '0;
                        state   <= RESP;
                    end else if (to_hit) begin
                        m_rdata      <= '0;
                        m_err        <= 1'b1;
                        m_ready      <= 1'b1;
                        timeout_flag <= 1'b1;
                        s_ren        <= '0;
                        s_wen        <= '0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter_nslave.sv
// Directed bench for bus_arbiter_nslave: stimulus pushes expected responses, a negedge
// monitor pops and compares on every m_ready pulse.

module tb_bus_arbiter_nslave;
    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  m_addr, m_wdata;
    logic         m_ren, m_wen;
    logic         m_ready, m_err, timeout_flag;
    logic [31:0]  m_rdata, s_addr, s_wdata;
    logic [3:0]   s_ren, s_wen, s_ack;
    logic [127:0] s_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    bus_arbiter_nslave #(
        .NUM_SLAVES     (4),
        .ADDR_W         (32),
        .DATA_W         (32),
        .REGION_BASE    ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .REGION_MASK    ({4{32'hF000_0000}}),
        .DEFAULT_SLAVE  (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ren        (m_ren),
        .m_wen        (m_wen),
        .m_ready      (m_ready),
        .m_rdata      (m_rdata),
        .m_err        (m_err),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_ren        (s_ren),
        .s_wen        (s_wen),
        .s_rdata      (s_rdata),
        .s_ack        (s_ack),
        .timeout_flag (timeout_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every m_ready must match the oldest expected response.
    initial begin : monitor
        exp_t e;
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                vecs++;
                if (prev_ready) begin
                    errs++;
                    $display("FAIL ready_width: m_ready high on consecutive cycles");
                end else if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_ready: rdata %h err %b with nothing expected", m_rdata, m_err);
                end else begin
                    e = exp_q.pop_front();
                    if (m_rdata !== e.rdata || m_err !== e.err) begin
                        errs++;
                        $display("FAIL response: got rdata %h err %b expected rdata %h err %b",
                                 m_rdata, m_err, e.rdata, e.err);
                    end
                end
            end
            prev_ready = (m_ready === 1'b1);
        end
    end

    // One transfer. ack_dly: WAIT cycle index in which the slave acks (-1 = never).
    // exp_held: expected number of cycles the strobe stays high (0 = error, no strobe).
    task automatic xfer(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rd, input logic wr, input int slv, input int ack_dly,
                        input logic [3:0] noise, input logic [31:0] sdata,
                        input logic [3:0] exp_oh, input int exp_held,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        int   held;
        int   bad_stable;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        m_addr = addr; m_wdata = wdata; m_ren = rd; m_wen = wr;
        @(posedge clk); #1;
        m_ren = 1'b0; m_wen = 1'b0;
        m_addr = 32'hFFFF_FFFF; m_wdata = 32'h0;
        if (exp_held == 0) begin
            @(negedge clk);
            chk({name, "_nostrobe"}, {24'h0, s_ren, s_wen}, 32'h0);
            @(posedge clk); #1;
            return;
        end
        held = 0;
        bad_stable = 0;
        for (int c = 0; c < 40; c++) begin
            s_ack = noise;
            if (c == ack_dly) begin
                s_ack[slv] = 1'b1;
                s_rdata[slv*32 +: 32] = sdata;
            end
            @(negedge clk);
            if ({s_ren, s_wen} != (rd ? {exp_oh, 4'b0} : {4'b0, exp_oh})) break;
            if (s_addr !== addr || s_wdata !== wdata) bad_stable++;
            held++;
            @(posedge clk); #1;
        end
        s_ack = '0;
        chk({name, "_strobe_cycles"}, held, exp_held);
        chk({name, "_addr_wdata_stable"}, bad_stable, 0);
        chk({name, "_strobe_dropped"}, {24'h0, s_ren, s_wen}, 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        reset = 1'b1; m_addr = '0; m_wdata = '0; m_ren = 1'b0; m_wen = 1'b0;
        s_ack = '0; s_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_ready", {31'h0, m_ready}, 32'h0);
        chk("rst_m_err", {31'h0, m_err}, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_strobes", {24'h0, s_ren, s_wen}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_timeout_flag", {31'h0, timeout_flag}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Read slave 2, immediate ack.
        xfer("rd_s2", 32'h2000_0010, 32'h0, 1'b1, 1'b0, 2, 0, 4'b0000, 32'hDEAD_BEEF,
             4'b0100, 1, 32'hDEAD_BEEF, 1'b0);
        // Unmapped address with no default slave: decode error, rdata cleared.
        xfer("dec_err", 32'h4000_0000, 32'h0, 1'b1, 1'b0, 0, 0, 4'b0000, 32'h0,
             4'b0000, 0, 32'h0, 1'b1);
        // Write slave 1, ack after 5 cycles; slave read data must not leak into m_rdata.
        xfer("wr_s1", 32'h1000_0004, 32'h0000_0055, 1'b0, 1'b1, 1, 5, 4'b0000, 32'hFFFF_FFFF,
             4'b0010, 6, 32'h0, 1'b0);
        // Ack on the very cycle the watchdog limit is reached.
        xfer("ack_at_limit", 32'h3000_0020, 32'h0, 1'b1, 1'b0, 3, 7, 4'b0000, 32'h1234_5678,
             4'b1000, 8, 32'h1234_5678, 1'b0);
        chk("flag_after_limit_ack", {31'h0, timeout_flag}, 32'h0);
        // Slave 3 never acks; other slaves ack continuously and must be ignored.
        xfer("timeout_s3", 32'h3000_0000, 32'h0, 1'b1, 1'b0, 3, -1, 4'b0111, 32'h0,
             4'b1000, 8, 32'h0, 1'b1);
        chk("flag_after_timeout", {31'h0, timeout_flag}, 32'h1);
        xfer("rd_s0", 32'h0000_0040, 32'h0, 1'b1, 1'b0, 0, 2, 4'b0000, 32'hA5A5_0001,
             4'b0001, 3, 32'hA5A5_0001, 1'b0);
        chk("flag_sticky", {31'h0, timeout_flag}, 32'h1);
        // Simultaneous read and write request.
        xfer("rd_and_wr", 32'h1000_0000, 32'h0000_0077, 1'b1, 1'b1, 0, 0, 4'b0000, 32'h0,
             4'b0000, 0, 32'h0, 1'b1);

        // Reset while a read to slave 0 is waiting: no ready for the aborted transfer.
        @(posedge clk); #1;
        m_addr = 32'h0000_0100; m_ren = 1'b1;
        @(posedge clk); #1;
        m_ren = 1'b0;
        @(negedge clk);
        chk("abort_strobe_up", {28'h0, s_ren}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_pre_edge_strobe", {28'h0, s_ren}, 32'h1);
        @(negedge clk);
        chk("abort_strobes_dropped", {24'h0, s_ren, s_wen}, 32'h0);
        chk("abort_no_ready", {31'h0, m_ready}, 32'h0);
        chk("abort_flag_cleared", {31'h0, timeout_flag}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        xfer("rd_after_rst", 32'h1000_0008, 32'h0, 1'b1, 1'b0, 1, 1, 4'b0000, 32'hCAFE_F00D,
             4'b0010, 2, 32'hCAFE_F00D, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
